// File: rtl/mult_share_pkg.sv
// Shared types and widths for the multiplier-sharing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mult_share_pkg;

  localparam int OP_W   = 8;   // multiplier operand width
  localparam int PROD_W = 16;  // multiplier product width
  localparam int TMO_W  = 4;   // timeout counter width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Last counter value before the timeout fires. Counting starts at zero in
  // the first BUSY cycle, so TIMEOUT BUSY cycles end on TIMEOUT-1.
  function automatic logic [TMO_W-1:0] tmo_last(input int timeout);
    return TMO_W'(timeout - 1);
  endfunction

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Bundle of requester-side and multiplier-side signals of the sharing controller.
// Latency: n/a (wiring only).
// Backpressure: req is a level held by each client until its one-cycle ack.
// Ports: req/dataa_in/datab_in from clients; ack/result/err/busy/grant_idx to clients;
//        mult_dataa/mult_datab/mult_start to the multiplier; mult_done/mult_product back.
interface mult_share_ctrl_if import mult_share_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) ();

  logic [NUM_REQ-1:0]      req;
  logic [OP_W*NUM_REQ-1:0] dataa_in;
  logic [OP_W*NUM_REQ-1:0] datab_in;
  logic [NUM_REQ-1:0]      ack;
  logic [PROD_W-1:0]       result;
  logic                    err;
  logic                    busy;
  logic [IDX_W-1:0]        grant_idx;
  logic [OP_W-1:0]         mult_dataa;
  logic [OP_W-1:0]         mult_datab;
  logic                    mult_start;
  logic                    mult_done;
  logic [PROD_W-1:0]       mult_product;

  // Environment side: clients plus the multiplier instance.
  modport master (
    output req, dataa_in, datab_in, mult_done, mult_product,
    input  ack, result, err, busy, grant_idx, mult_dataa, mult_datab, mult_start
  );

  // Controller side.
  modport slave (
    input  req, dataa_in, datab_in, mult_done, mult_product,
    output ack, result, err, busy, grant_idx, mult_dataa, mult_datab, mult_start
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: first set request at or above ptr_i, wrapping to the bottom.
// Latency: combinational.
// Backpressure: none; vld_o simply reports whether any request is present.
// Ports: req_i request vector, ptr_i search start; vld_o any request, idx_o winner.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               vld_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [NUM_REQ-1:0] upper;
  logic               up_vld;
  logic [IDX_W-1:0]   up_idx;
  logic [IDX_W-1:0]   all_idx;

  // Two priority searches: one restricted to requests at or above the pointer,
  // one over everything. The restricted one wins; the other covers the wrap.
  always_comb begin
    upper   = '0;
    up_vld  = 1'b0;
    up_idx  = '0;
    all_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper[i] = req_i[i] && (IDX_W'(i) >= ptr_i);
    end
    // Scan downward so the lowest set bit is the one left standing.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (upper[i]) begin
        up_vld = 1'b1;
        up_idx = IDX_W'(i);
      end
      if (req_i[i]) begin
        all_idx = IDX_W'(i);
      end
    end
    vld_o = |req_i;
    idx_o = up_vld ? up_idx : all_idx;
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one sequential 8x8 multiplier among NUM_REQ clients with round-robin arbitration.
// Latency: req seen in IDLE at cycle 0 -> start at 1 -> ack one cycle after accepted done (or timeout).
// Backpressure: clients hold req/operands until ack; one operation in flight, others wait in rr order.
// Ports: clk, reset_a (async active-low), bus (slave side of mult_share_ctrl_if).
module mult_share_ctrl import mult_share_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_a,
  mult_share_ctrl_if.slave bus
);

  localparam logic [TMO_W-1:0] TMO_LAST = tmo_last(TIMEOUT);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [PROD_W-1:0]   result_q, result_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                start_q, start_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     b_q, b_d;

  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic [OP_W-1:0]     a_sel, b_sel;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  // Operand slice of the arbitration winner.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        a_sel = bus.dataa_in[i*OP_W +: OP_W];
        b_sel = bus.datab_in[i*OP_W +: OP_W];
      end
    end
  end

  // Every output is a register, so each is computed here for the cycle after
  // the transition: start is raised while leaving IDLE, ack while entering RESP.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    result_d = result_q;
    err_d    = err_q;
    start_d  = 1'b0;
    a_d      = a_q;
    b_d      = b_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          a_d     = a_sel;
          b_d     = b_sel;
          start_d = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // Done in the first BUSY cycle may still be the previous operation's level.
        if (bus.mult_done && (cnt_q != '0)) begin
          result_d = bus.mult_product;
          err_d    = 1'b0;
          ack_d    = NUM_REQ'(1) << grant_q;
          state_d  = ST_RESP;
        end else if (cnt_q == TMO_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          ack_d    = NUM_REQ'(1) << grant_q;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.result     = result_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
  assign bus.grant_idx  = grant_q;
  assign bus.mult_dataa = a_q;
  assign bus.mult_datab = b_q;
  assign bus.mult_start = start_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Randomized and directed bench for mult_share_ctrl with a timeline reference model.
// Latency: n/a.
// Backpressure: clients hold req until their ack; the multiplier model reacts to start.
module tb_mult_share_ctrl;
  import mult_share_pkg::*;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic reset_a;
  always #5 clk = ~clk;

  mult_share_ctrl_if #(.NUM_REQ(N), .IDX_W(IW)) bus ();

  mult_share_ctrl #(.NUM_REQ(N), .IDX_W(IW), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_a (reset_a),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // client side
  logic [N-1:0] req_r;
  logic [7:0]   opa [N];
  logic [7:0]   opb [N];
  bit           rerequest, in_reset, rand_mode;

  // multiplier model
  int           dir_delay = 3;
  bit           dir_stale = 0;
  int           mul_s = -10, mul_done_at = 1 << 30;
  bit           mul_stale, old_done, cur_done;
  logic [15:0]  old_prod, new_prod, cur_prod;
  int           last_start_cyc = -1;

  // reference model: timeline of the operation in flight
  bit           m_op;
  int           m_t0, m_tack, m_g, m_ptr;
  logic [7:0]   m_a, m_b;
  logic [N-1:0] e_ack;
  logic [15:0]  e_res;
  logic         e_err, e_busy, e_start;
  logic [IW-1:0] e_grant;
  logic [7:0]   e_a, e_b;

  // completions seen on the DUT
  int log_idx[$];
  int log_res[$];
  int log_err[$];
  int log_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int n = 0; n < N; n++) begin
      if (r[(p + n) % N]) return (p + n) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_op = 0; m_ptr = 0; m_tack = -1;
    e_ack = '0; e_res = '0; e_err = 0; e_busy = 0; e_start = 0;
    e_grant = '0; e_a = '0; e_b = '0;
  endtask

  task automatic drive();
    bus.req = req_r;
    for (int i = 0; i < N; i++) begin
      bus.dataa_in[i*8 +: 8] = opa[i];
      bus.datab_in[i*8 +: 8] = opb[i];
    end
    bus.mult_done    = cur_done;
    bus.mult_product = cur_prod;
  endtask

  // One call per negedge: compare, react as clients/multiplier, advance the model.
  task automatic step();
    int j;
    int dly;
    chk("ack",        bus.ack,        e_ack);
    chk("result",     bus.result,     e_res);
    chk("err",        bus.err,        e_err);
    chk("busy",       bus.busy,       e_busy);
    chk("grant_idx",  bus.grant_idx,  e_grant);
    chk("mult_dataa", bus.mult_dataa, e_a);
    chk("mult_datab", bus.mult_datab, e_b);
    chk("mult_start", bus.mult_start, e_start);

    if (bus.ack != '0) begin
      for (int i = N - 1; i >= 0; i--) if (bus.ack[i]) j = i;
      log_idx.push_back(j);
      log_res.push_back(int'(bus.result));
      log_err.push_back(int'(bus.err));
      log_cyc.push_back(cyc);
    end

    for (int i = 0; i < N; i++) if (bus.ack[i]) req_r[i] = rerequest;
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!req_r[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            req_r[i] = 1'b1;
            opa[i] = 8'($urandom);
            opb[i] = 8'($urandom);
          end
        end else if ($urandom_range(0, 99) == 0) begin
          req_r[i] = 1'b0;
        end
      end
      // Operands of the client being served are irrelevant once sampled.
      if (m_op && $urandom_range(0, 3) == 0) begin
        opa[m_g] = 8'($urandom);
        opb[m_g] = 8'($urandom);
      end
    end

    if (bus.mult_start === 1'b1) begin
      last_start_cyc = cyc;
      old_done = cur_done;
      old_prod = cur_prod;
      new_prod = 16'(bus.mult_dataa) * 16'(bus.mult_datab);
      mul_s = cyc;
      if (rand_mode) begin
        dly = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(2, 17));
        mul_stale = 1'($urandom_range(0, 1));
      end else begin
        dly = dir_delay;
        mul_stale = dir_stale;
      end
      mul_done_at = cyc + dly;
    end
    if (cyc >= mul_done_at) begin
      cur_done = 1'b1; cur_prod = new_prod;
    end else if (cyc <= mul_s + (mul_stale ? 1 : 0)) begin
      cur_done = old_done; cur_prod = old_prod;
    end else begin
      cur_done = 1'b0; cur_prod = old_prod;
    end

    drive();
    reset_a = in_reset ? 1'b0 : 1'b1;

    if (!in_reset) begin
      e_start = 1'b0;
      e_ack   = '0;
      if (m_op && cyc == m_tack) begin
        m_ptr = (m_g + 1) % N;
        m_op = 0;
        e_busy = 1'b0;
      end else if (!m_op) begin
        if (req_r != '0) begin
          m_g = pick(req_r, m_ptr);
          m_op = 1; m_t0 = cyc; m_tack = -1;
          m_a = opa[m_g]; m_b = opb[m_g];
          e_grant = IW'(m_g); e_a = m_a; e_b = m_b;
          e_start = 1'b1; e_busy = 1'b1;
        end
      end else if (cyc >= m_t0 + 2) begin
        j = cyc - (m_t0 + 2);
        if (cur_done && j >= 1) begin
          e_res = 16'(m_a) * 16'(m_b); e_err = 1'b0;
          e_ack = N'(1) << m_g; m_tack = cyc + 1;
        end else if (j == TMO - 1) begin
          e_res = '0; e_err = 1'b1;
          e_ack = N'(1) << m_g; m_tack = cyc + 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      step();
    end
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int b = 0;
    while (log_idx.size() < target && b < budget) begin
      run(1);
      b++;
    end
    chk({name, "_ack_count"}, log_idx.size(), target);
  endtask

  task automatic wait_idle(input int budget);
    int b = 0;
    while ((m_op || req_r != '0) && b < budget) begin
      run(1);
      b++;
    end
    chk("drain_idle", {31'd0, m_op}, 32'd0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2 reset_a = 1'b0;
    #1;
    chk("rst_ack",    bus.ack,        0);
    chk("rst_result", bus.result,     0);
    chk("rst_err",    bus.err,        0);
    chk("rst_busy",   bus.busy,       0);
    chk("rst_grant",  bus.grant_idx,  0);
    chk("rst_dataa",  bus.mult_dataa, 0);
    chk("rst_datab",  bus.mult_datab, 0);
    chk("rst_start",  bus.mult_start, 0);
    model_reset();
    in_reset = 1;
    run(2);
    in_reset = 0;
    run(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t0, n_ok, n_to;
    reset_a = 1'b1;
    req_r = '0; rerequest = 0; in_reset = 0; rand_mode = 0;
    cur_done = 0; cur_prod = '0; old_done = 0; old_prod = '0; new_prod = '0; mul_stale = 0;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    drive();
    async_reset();

    // 1: single request, done 4 cycles after start
    dir_delay = 4;
    opa[1] = 8'd12; opb[1] = 8'd10;
    base = log_idx.size(); t0 = cyc; req_r = 4'b0010;
    wait_acks(base + 1, 40, "t1");
    chk("t1_idx", log_idx[base], 1);
    chk("t1_result", log_res[base], 32'h78);
    chk("t1_err", log_err[base], 0);
    chk("t1_start_lat", last_start_cyc - t0, 1);
    chk("t1_ack_lat", log_cyc[base] - t0, 6);
    wait_idle(50);

    // 2: all four contend and re-request immediately
    async_reset();
    dir_delay = 3; rerequest = 1;
    for (int i = 0; i < N; i++) begin opa[i] = 8'(i + 1); opb[i] = 8'd255; end
    base = log_idx.size(); req_r = 4'b1111;
    wait_acks(base + 5, 200, "t2");
    for (int k = 0; k < 5; k++) begin
      chk("t2_idx", log_idx[base + k], k % 4);
      chk("t2_result", log_res[base + k], ((k % 4) + 1) * 255);
    end
    rerequest = 0;
    wait_idle(200);

    // 3: wrap and pointer
    async_reset();
    base = log_idx.size(); req_r = 4'b1000;
    wait_acks(base + 1, 40, "t3a");
    wait_idle(50);
    req_r = 4'b1001;
    wait_acks(base + 3, 80, "t3b");
    wait_idle(50);
    req_r = 4'b1000;
    wait_acks(base + 4, 40, "t3c");
    chk("t3_first", log_idx[base], 3);
    chk("t3_then0", log_idx[base + 1], 0);
    chk("t3_then3", log_idx[base + 2], 3);
    chk("t3_last3", log_idx[base + 3], 3);
    wait_idle(50);

    // 4: timeout, then done landing on the timeout cycle
    dir_delay = 1000; opa[0] = 8'd7; opb[0] = 8'd9;
    base = log_idx.size(); t0 = cyc; req_r = 4'b0001;
    wait_acks(base + 1, 60, "t4a");
    chk("t4_to_err", log_err[base], 1);
    chk("t4_to_result", log_res[base], 0);
    chk("t4_to_lat", log_cyc[base] - t0, 17);
    wait_idle(50);
    dir_delay = 15; opa[2] = 8'd13; opb[2] = 8'd11;
    t0 = cyc; req_r = 4'b0100;
    wait_acks(base + 2, 60, "t4b");
    chk("t4_tie_err", log_err[base + 1], 0);
    chk("t4_tie_result", log_res[base + 1], 143);
    chk("t4_tie_lat", log_cyc[base + 1] - t0, 17);
    wait_idle(50);

    // 5: stale done still high in the first BUSY cycle
    dir_delay = 2; dir_stale = 1; opa[1] = 8'd200; opb[1] = 8'd3;
    base = log_idx.size(); t0 = cyc; req_r = 4'b0010;
    wait_acks(base + 1, 40, "t5a");
    chk("t5_result", log_res[base], 600);
    chk("t5_lat", log_cyc[base] - t0, 4);
    wait_idle(50);
    dir_delay = 3; opa[3] = 8'd255; opb[3] = 8'd255;
    t0 = cyc; req_r = 4'b1000;
    wait_acks(base + 2, 40, "t5b");
    chk("t5b_result", log_res[base + 1], 32'hFE01);
    chk("t5b_lat", log_cyc[base + 1] - t0, 5);
    wait_idle(50);
    dir_stale = 0;

    // 6: reset while serving 3; pending 2 goes first afterwards
    req_r = 4'b0100;
    wait_acks(log_idx.size() + 1, 40, "t6pre");
    wait_idle(50);
    dir_delay = 1000; req_r = 4'b1100; opa[2] = 8'd5; opb[2] = 8'd6;
    run(6);
    chk("t6_grant_before_rst", bus.grant_idx, 3);
    chk("t6_busy_before_rst", bus.busy, 1);
    dir_delay = 3;
    base = log_idx.size();
    async_reset();
    wait_acks(base + 2, 80, "t6");
    chk("t6_first", log_idx[base], 2);
    chk("t6_first_result", log_res[base], 30);
    chk("t6_second", log_idx[base + 1], 3);
    wait_idle(50);

    // randomized traffic
    base = log_idx.size();
    rand_mode = 1;
    run(3000);
    rand_mode = 0; dir_delay = 3;
    wait_idle(400);
    n_ok = 0; n_to = 0;
    for (int k = base; k < log_idx.size(); k++) begin
      if (log_err[k] != 0) n_to++; else n_ok++;
    end
    chk("rand_saw_ok", {31'd0, n_ok > 20}, 1);
    chk("rand_saw_timeout", {31'd0, n_to > 0}, 1);
    run(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
Controller that shares one 8x8 sequential multiplier (the `seq_mult` datapath) between NUM_REQ requesters.
- Arbitrates round-robin among pending requests.
- Latches the winner's operands and pulses the multiplier start.
- Waits for done and supervises it with a timeout.
- Returns the 16-bit product to the winner with a one-cycle ack.
- Sits between client blocks and the single multiplier instance in the top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 2, grant index width, clog2(NUM_REQ)
TIMEOUT, 15, max BUSY cycles before abort (fits 4-bit counter; 1..15)

Ports:
clk  in  1  system clock, rising edge
reset_a  in  1  asynchronous reset, active-low
req  in  NUM_REQ  per-requester request level
dataa_in  in  8*NUM_REQ  packed operand A, slice i = requester i
datab_in  in  8*NUM_REQ  packed operand B, slice i = requester i
ack  out  NUM_REQ  one-hot, one-cycle completion pulse
result  out  16  product of last completed operation
err  out  1  valid with ack: 1 = timeout abort
busy  out  1  high in any state other than IDLE
grant_idx  out  IDX_W  index of requester currently served
mult_dataa  out  8  operand A to multiplier
mult_datab  out  8  operand B to multiplier
mult_start  out  1  start pulse to multiplier
mult_done  in  1  multiplier done level
mult_product  in  16  multiplier product

Behaviour:
- Reset (reset_a=0, asynchronous): state IDLE, rr pointer=0, all outputs 0 (ack, result, err, busy, grant_idx, mult_dataa, mult_datab, mult_start).
- All outputs are registered.
- FSM states: IDLE, LOAD, BUSY, RESP.
- IDLE:
  - If req!=0, pick the first set bit searching upward from the rr pointer, wrapping.
  - Register grant_idx and that slice's operands into mult_dataa/mult_datab.
  - Go to LOAD.
  - If req==0, stay in IDLE.
- LOAD: mult_start=1 for exactly this one cycle; clear timeout counter; go to BUSY.
- BUSY:
  - Timeout counter increments each cycle.
  - mult_done is ignored in the first BUSY cycle (counter==0), which masks a stale done from the previous operation.
  - mult_done=1 with counter>=1: result<=mult_product, err<=0, go to RESP.
  - Counter reaches TIMEOUT without done: result<=0, err<=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins (err=0).
- RESP:
  - ack[grant_idx]=1 for one cycle.
  - rr pointer <= grant_idx+1, wrapping to 0 after NUM_REQ-1.
  - Go to IDLE.
- result and err hold until the next RESP.
- Latency: req seen in IDLE at cycle 0 -> mult_start at cycle 1 -> ack at cycle (d+1), where d is the first cycle >= 3 with mult_done high.
- Operands are sampled only in IDLE; later changes on dataa_in/datab_in have no effect.
- Requesters:
  - Hold req and operands until ack.
  - Must drop req in the cycle following ack; otherwise they are re-arbitrated as a new request.
- req dropped mid-operation: the operation still completes and ack is still issued; the requester discards it.
- Simultaneous requests are served in rr order. No requester waits more than NUM_REQ-1 other operations.
- mult_dataa/mult_datab hold their value through BUSY and RESP.
- Reset mid-operation aborts immediately with no ack; the multiplier is restarted by the next LOAD.

Decomposition:
- Package mult_share_pkg: state encoding (IDLE=0, LOAD=1, BUSY=2, RESP=3), operand width 8, product width 16, timeout counter width 4.
- Sub-module rr_pick: combinational round-robin selector. Inputs: req vector, pointer. Outputs: any-valid flag, winner index.

Test Plan:
1. Single request: req=4'b0010, slice1 A=8'd12, B=8'd10; multiplier model with done 4 cycles after start -> mult_start pulse at cycle 1, ack=4'b0010 one cycle, result=16'h0078, err=0.
2. Contention: req=4'b1111 held, each requester re-requesting immediately after its ack -> grants in order 0,1,2,3,0; each ack one-hot; operands A=i+1, B=8'd255 give results 255, 510, 765, 1020.
3. Wrap and pointer: after serving 3, req=4'b1001 -> 0 granted before 3; then req=4'b1000 only -> 3 granted.
4. Timeout: model never asserts done -> ack after TIMEOUT=15 BUSY cycles, err=1, result=0; next request completes normally with err=0.
5. Stale done: mult_done stuck high from previous op during first BUSY cycle -> ignored; completion taken from cycle >=2 of BUSY with the new product.
6. Reset mid-BUSY: drive reset_a=0 during BUSY -> all outputs 0 asynchronously, no ack; after release, pending req=4'b0100 is granted first, since the pointer is back at 0 and no lower request is pending.
